// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM with a
// 1-cycle registered read. It keeps the pointers, occupancy and error flags.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_LVL  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err,
  output logic                  ram_r_en,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_r_data,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_prev;
  logic                  push_ok, pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign wr_ptr_nxt = wr_ptr + PW'(push_ok);
  assign rd_ptr_nxt = rd_ptr + PW'(pop_ok);

  // Occupancy follows from the wrap-bit pointers; +1 on push only, -1 on pop only.
  assign count     = wr_ptr - rd_ptr;
  assign count_nxt = wr_ptr_nxt - rd_ptr_nxt;

  assign ram_w_en   = push_ok;
  assign ram_w_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_w_data = push_data;

  // The idle read address normally points at the last freed slot. With one
  // free slot left, that slot is exactly the write target. In that case the
  // address is moved to rd_addr instead, which still holds live data.
  assign rd_addr    = rd_ptr[ADDR_WIDTH-1:0];
  assign rd_prev    = rd_addr - ADDR_WIDTH'(1);
  assign ram_r_en   = pop_ok;
  assign ram_r_addr = pop_ok ? rd_addr :
                      (rd_prev == ram_w_addr) ? rd_addr : rd_prev;

  assign pop_data = ram_r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      pop_valid   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == PW'(RAM_DEPTH));
      almost_full <= (count_nxt >= PW'(AFULL_LVL));
      pop_valid   <= pop_ok;
      // A new error wins over a simultaneous clear.
      overflow    <= (push & full)  | (overflow  & ~clr_err);
      underflow   <= (pop  & empty) | (underflow & ~clr_err);
    end
  end

  a_no_rw_conflict: assert property (@(posedge clk) disable iff (!rst_n)
    ram_w_en |-> (ram_r_addr != ram_w_addr));

endmodule
